// File: rtl/wb_reg_file_pkg.sv
// Shared constants for the MIPS write-back register file: architectural register
// indices and default geometry/reset values.
package wb_reg_file_pkg;

  localparam int unsigned DATA_W_DEF  = 32;
  localparam int unsigned ADDR_W_DEF  = 5;
  localparam int unsigned SP_INIT_DEF = 128;

  localparam int unsigned REG_ZERO = 0;
  localparam int unsigned REG_SP   = 29;
  localparam int unsigned REG_RA   = 31;

endpackage : wb_reg_file_pkg

// File: rtl/wb_read_port.sv
// One combinational read port of the register file: applies the $zero, reset-image
// and same-cycle write bypass rules on top of the stored word.
module wb_read_port
  import wb_reg_file_pkg::*;
#(
  parameter int unsigned          DATA_W  = DATA_W_DEF,
  parameter int unsigned          ADDR_W  = ADDR_W_DEF,
  parameter logic [DATA_W-1:0]    SP_INIT = DATA_W'(SP_INIT_DEF)
) (
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] stored,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rst,
  output logic [DATA_W-1:0] rd_data
);

  always_comb begin
    // NOTE: default first so every path assigns rd_data and no latch is inferred.
    rd_data = '0;
    if (rd_addr == ADDR_W'(REG_ZERO)) begin
      rd_data = '0;
    end else if (rst) begin
      // Reset image wins over both storage and bypass while reset is held.
      rd_data = (rd_addr == ADDR_W'(REG_SP)) ? SP_INIT : '0;
    end else if (wr_en && (wr_addr == rd_addr)) begin
      // rd_addr is non-zero here, so wr_addr is too; index 0 can never bypass.
      rd_data = wr_data;
    end else begin
      rd_data = stored;
    end
  end

endmodule : wb_read_port

// File: rtl/wb_reg_file.sv
// 32x32 MIPS general register file fed by the ToReg write-back mux, with two
// combinational read ports (rs, rt) and read-during-write bypass.
module wb_reg_file
  import wb_reg_file_pkg::*;
#(
  parameter int unsigned          DATA_W  = DATA_W_DEF,
  parameter int unsigned          ADDR_W  = ADDR_W_DEF,
  parameter logic [DATA_W-1:0]    SP_INIT = DATA_W'(SP_INIT_DEF)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic [ADDR_W-1:0] rs_addr_i,
  input  logic [ADDR_W-1:0] rt_addr_i,
  output logic [DATA_W-1:0] rs_data_o,
  output logic [DATA_W-1:0] rt_data_o
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [0:DEPTH-1];

  // NOTE: the whole array is reset on purpose: software relies on a defined $sp and
  // zeroed registers after reset, which rules out a plain RAM macro here.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        // NOTE: non-blocking assignments for all sequential state.
        regs[i] <= (i == REG_SP) ? SP_INIT : '0;
      end
    end else if (wr_en_i && (wr_addr_i != ADDR_W'(REG_ZERO))) begin
      regs[wr_addr_i] <= wr_data_i;
    end
  end

  wb_read_port #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .SP_INIT (SP_INIT)
  ) u_rs_port (
    .rd_addr (rs_addr_i),
    .stored  (regs[rs_addr_i]),
    .wr_en   (wr_en_i),
    .wr_addr (wr_addr_i),
    .wr_data (wr_data_i),
    .rst     (rst_i),
    .rd_data (rs_data_o)
  );

  wb_read_port #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .SP_INIT (SP_INIT)
  ) u_rt_port (
    .rd_addr (rt_addr_i),
    .stored  (regs[rt_addr_i]),
    .wr_en   (wr_en_i),
    .wr_addr (wr_addr_i),
    .wr_data (wr_data_i),
    .rst     (rst_i),
    .rd_data (rt_data_o)
  );

endmodule : wb_reg_file

// File: tb/tb_wb_reg_file.sv
// Self-checking bench for wb_reg_file: directed scenarios plus a randomized run
// against an array-based reference model of the architectural registers.
module tb_wb_reg_file;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        wr_en_i;
  logic [4:0]  wr_addr_i;
  logic [31:0] wr_data_i;
  logic [4:0]  rs_addr_i;
  logic [4:0]  rt_addr_i;
  logic [31:0] rs_data_o;
  logic [31:0] rt_data_o;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] model [32];

  always #5 clk_i = ~clk_i;

  wb_reg_file dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .wr_en_i   (wr_en_i),
    .wr_addr_i (wr_addr_i),
    .wr_data_i (wr_data_i),
    .rs_addr_i (rs_addr_i),
    .rt_addr_i (rt_addr_i),
    .rs_data_o (rs_data_o),
    .rt_data_o (rt_data_o)
  );

  // Architectural view of a read given the current inputs.
  function automatic logic [31:0] exp_read(input logic [4:0] a);
    if (a == 5'd0)                        return 32'd0;
    if (rst_i)                            return (a == 5'd29) ? 32'd128 : 32'd0;
    if (wr_en_i && wr_addr_i == a)        return wr_data_i;
    return model[a];
  endfunction

  // Advance one clock edge and apply the same edge to the model.
  task automatic cycle();
    @(posedge clk_i);
    if (rst_i) begin
      for (int i = 0; i < 32; i++) model[i] = (i == 29) ? 32'd128 : 32'd0;
    end else if (wr_en_i && wr_addr_i != 5'd0) begin
      model[wr_addr_i] = wr_data_i;
    end
    #1;
  endtask

  task automatic test_reset();
    logic [4:0]  idxs [4] = '{5'd0, 5'd5, 5'd29, 5'd31};
    logic [31:0] exps [4] = '{32'd0, 32'd0, 32'd128, 32'd0};
    rst_i = 1'b1; wr_en_i = 1'b1; wr_addr_i = 5'd5; wr_data_i = 32'hDEAD;
    rs_addr_i = 5'd5; rt_addr_i = 5'd29;
    #1;
    n_checks++;
    if (rs_data_o !== 32'd0) begin
      n_fail++; $display("FAIL reset_no_bypass_rs5: got %h expected %h", rs_data_o, 32'd0);
    end
    n_checks++;
    if (rt_data_o !== 32'd128) begin
      n_fail++; $display("FAIL reset_image_rt29: got %h expected %h", rt_data_o, 32'd128);
    end
    cycle();
    rst_i = 1'b0; wr_en_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      rs_addr_i = idxs[k]; rt_addr_i = idxs[k];
      #1;
      n_checks++;
      if (rs_data_o !== exps[k]) begin
        n_fail++; $display("FAIL reset_rs_idx%0d: got %h expected %h", idxs[k], rs_data_o, exps[k]);
      end
      n_checks++;
      if (rt_data_o !== exps[k]) begin
        n_fail++; $display("FAIL reset_rt_idx%0d: got %h expected %h", idxs[k], rt_data_o, exps[k]);
      end
    end
  endtask

  task automatic test_basic_write();
    wr_en_i = 1'b1; wr_addr_i = 5'd8; wr_data_i = 32'h1234_5678;
    rs_addr_i = 5'd1; rt_addr_i = 5'd2;
    cycle();
    wr_en_i = 1'b0; rs_addr_i = 5'd8;
    for (int k = 0; k < 11; k++) begin
      #1;
      n_checks++;
      if (rs_data_o !== 32'h1234_5678) begin
        n_fail++; $display("FAIL basic_write_persist_c%0d: got %h expected %h", k, rs_data_o, 32'h1234_5678);
      end
      cycle();
    end
  endtask

  task automatic test_zero();
    wr_en_i = 1'b1; wr_addr_i = 5'd0; wr_data_i = 32'hFFFF_FFFF;
    rs_addr_i = 5'd0; rt_addr_i = 5'd0;
    #1;
    n_checks++;
    if (rs_data_o !== 32'd0) begin
      n_fail++; $display("FAIL zero_same_cycle: got %h expected %h", rs_data_o, 32'd0);
    end
    cycle();
    wr_en_i = 1'b0;
    #1;
    n_checks++;
    if (rt_data_o !== 32'd0) begin
      n_fail++; $display("FAIL zero_after_edge: got %h expected %h", rt_data_o, 32'd0);
    end
  endtask

  task automatic test_bypass();
    wr_en_i = 1'b1; wr_addr_i = 5'd9; wr_data_i = 32'hA;
    cycle();
    wr_data_i = 32'hB; rs_addr_i = 5'd9; rt_addr_i = 5'd9;
    #1;
    n_checks++;
    if (rs_data_o !== 32'hB) begin
      n_fail++; $display("FAIL bypass_rs: got %h expected %h", rs_data_o, 32'hB);
    end
    n_checks++;
    if (rt_data_o !== 32'hB) begin
      n_fail++; $display("FAIL bypass_rt: got %h expected %h", rt_data_o, 32'hB);
    end
    cycle();
    wr_en_i = 1'b0;
    #1;
    n_checks++;
    if (rs_data_o !== 32'hB || rt_data_o !== 32'hB) begin
      n_fail++; $display("FAIL bypass_after_edge: got rs=%h rt=%h expected %h", rs_data_o, rt_data_o, 32'hB);
    end
  endtask

  task automatic test_link();
    wr_en_i = 1'b1; wr_addr_i = 5'd31; wr_data_i = 32'h0040_0008;
    rt_addr_i = 5'd31; rs_addr_i = 5'd3;
    cycle();
    n_checks++;
    if (rt_data_o !== 32'h0040_0008) begin
      n_fail++; $display("FAIL link_first: got %h expected %h", rt_data_o, 32'h0040_0008);
    end
    wr_data_i = 32'h10;
    cycle();
    wr_en_i = 1'b0;
    #1;
    n_checks++;
    if (rt_data_o !== 32'h10) begin
      n_fail++; $display("FAIL link_second: got %h expected %h", rt_data_o, 32'h10);
    end
  endtask

  task automatic test_reset_mid();
    wr_en_i = 1'b1; wr_addr_i = 5'd29; wr_data_i = 32'h77;
    cycle();
    rst_i = 1'b1; wr_en_i = 1'b0;
    cycle();
    rst_i = 1'b0; rs_addr_i = 5'd29; rt_addr_i = 5'd8;
    #1;
    n_checks++;
    if (rs_data_o !== 32'd128) begin
      n_fail++; $display("FAIL reset_mid_sp: got %h expected %h", rs_data_o, 32'd128);
    end
    n_checks++;
    if (rt_data_o !== 32'd0) begin
      n_fail++; $display("FAIL reset_mid_r8: got %h expected %h", rt_data_o, 32'd0);
    end
    wr_en_i = 1'b1; wr_addr_i = 5'd8; wr_data_i = 32'h5;
    cycle();
    wr_en_i = 1'b0;
    #1;
    n_checks++;
    if (rt_data_o !== 32'h5) begin
      n_fail++; $display("FAIL reset_mid_rewrite: got %h expected %h", rt_data_o, 32'h5);
    end
  endtask

  task automatic test_random();
    logic [31:0] e_rs;
    logic [31:0] e_rt;
    for (int n = 0; n < 400; n++) begin
      rst_i     = ($urandom_range(0, 24) == 0);
      wr_en_i   = ($urandom_range(0, 2) != 0);
      rs_addr_i = 5'($urandom_range(0, 31));
      rt_addr_i = ($urandom_range(0, 3) == 0) ? rs_addr_i : 5'($urandom_range(0, 31));
      wr_addr_i = ($urandom_range(0, 2) == 0) ? rs_addr_i : 5'($urandom_range(0, 31));
      wr_data_i = $urandom;
      #1;
      e_rs = exp_read(rs_addr_i);
      e_rt = exp_read(rt_addr_i);
      n_checks++;
      if (rs_data_o !== e_rs) begin
        n_fail++; $display("FAIL rand_rs n=%0d idx=%0d: got %h expected %h", n, rs_addr_i, rs_data_o, e_rs);
      end
      n_checks++;
      if (rt_data_o !== e_rt) begin
        n_fail++; $display("FAIL rand_rt n=%0d idx=%0d: got %h expected %h", n, rt_addr_i, rt_data_o, e_rt);
      end
      cycle();
    end
    rst_i = 1'b0; wr_en_i = 1'b0;
    for (int a = 0; a < 32; a++) begin
      rs_addr_i = 5'(a);
      #1;
      e_rs = (a == 0) ? 32'd0 : model[a];
      n_checks++;
      if (rs_data_o !== e_rs) begin
        n_fail++; $display("FAIL rand_final idx=%0d: got %h expected %h", a, rs_data_o, e_rs);
      end
    end
  endtask

  initial begin
    rst_i = 1'b0; wr_en_i = 1'b0; wr_addr_i = '0; wr_data_i = '0;
    rs_addr_i = '0; rt_addr_i = '0;
    @(negedge clk_i);
    test_reset();
    test_basic_write();
    test_zero();
    test_bypass();
    test_link();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_wb_reg_file
